// File: rtl/instruction_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch front end.
//   - Instruction-type codes (R..UJ plus ILLEGAL_TYPE).
//   - RISC-V base opcode constants.
//   - Fetch FSM state enum.
//   - classify_opcode(): opcode -> instruction-type code.
package instruction_fetch_queue_pkg;

  localparam logic [2:0] R_TYPE       = 3'd0;
  localparam logic [2:0] I_TYPE       = 3'd1;
  localparam logic [2:0] S_TYPE       = 3'd2;
  localparam logic [2:0] SB_TYPE      = 3'd3;
  localparam logic [2:0] U_TYPE       = 3'd4;
  localparam logic [2:0] UJ_TYPE      = 3'd5;
  localparam logic [2:0] ILLEGAL_TYPE = 3'b111;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_state_e;

  function automatic logic [2:0] classify_opcode(input logic [6:0] opcode);
    case (opcode)
      OP_OP, OP_OP_32:                                    return R_TYPE;
      OP_IMM, OP_IMM_32, OP_LOAD, OP_JALR, OP_SYSTEM:     return I_TYPE;
      OP_STORE:                                           return S_TYPE;
      OP_BRANCH:                                          return SB_TYPE;
      OP_LUI, OP_AUIPC:                                   return U_TYPE;
      OP_JAL:                                             return UJ_TYPE;
      default:                                            return ILLEGAL_TYPE;
    endcase
  endfunction

endpackage

// File: rtl/instruction_fetch_queue_opcode_classifier.sv
// opcode_classifier: combinational instruction-type lookup.
// Ports:
//   instruction      in  INSTRUCTION_LENGTH  raw instruction word
//   instruction_type out TYPE_WIDTH          type code from opcode [6:0]
module opcode_classifier
  import instruction_fetch_queue_pkg::*;
#(
  parameter int INSTRUCTION_LENGTH = 32,
  parameter int TYPE_WIDTH         = 3
) (
  input  logic [INSTRUCTION_LENGTH-1:0] instruction,
  output logic [TYPE_WIDTH-1:0]         instruction_type
);

  // Only the opcode field matters for classification.
  logic unused_upper;
  assign unused_upper = ^instruction[INSTRUCTION_LENGTH-1:7];

  assign instruction_type = TYPE_WIDTH'(classify_opcode(instruction[6:0]));

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: fetch front end. Issues aligned 64-bit fetches,
// splits each response into two instructions, classifies them and buffers
// them in a FIFO presented to decode over valid/ready.
// Optional feature: define IFQ_BYPASS_EN to let a response reach the outputs
// in the same cycle when the queue is empty.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   redirect_valid, redirect_pc      flush and restart fetch at redirect_pc
//   mem_req_valid/ready/addr         fetch request handshake (8-byte aligned)
//   mem_resp_valid, mem_resp_data    one-cycle response, [31:0] at addr
//   out_valid, out_ready             decode handshake
//   instruction, instruction_type, out_pc   head entry
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int                    ADDR_WIDTH         = 64,
  parameter int                    BUS_WIDTH          = 64,
  parameter int                    INSTRUCTION_LENGTH = 32,
  parameter int                    TYPE_WIDTH         = 3,
  parameter int                    DEPTH              = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC           = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  input  logic                          mem_resp_valid,
  input  logic [BUS_WIDTH-1:0]          mem_resp_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INSTRUCTION_LENGTH-1:0] instruction,
  output logic [TYPE_WIDTH-1:0]         instruction_type,
  output logic [ADDR_WIDTH-1:0]         out_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]      ROOM_MAX  = CNT_W'(DEPTH - 2);
  localparam logic [ADDR_WIDTH-1:0] HALF_STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(8);

  fetch_state_e            state, state_next;
  logic [ADDR_WIDTH-1:0]   fetch_pc;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    drop_pend;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;

  logic [INSTRUCTION_LENGTH-1:0] q_instr [DEPTH];
  logic [TYPE_WIDTH-1:0]         q_type  [DEPTH];
  logic [ADDR_WIDTH-1:0]         q_pc    [DEPTH];

  logic [INSTRUCTION_LENGTH-1:0] lo_instr, hi_instr;
  logic [TYPE_WIDTH-1:0]         lo_type, hi_type;
  logic [ADDR_WIDTH-1:0]         hi_pc;
  logic                          upper_only, resp_take, fifo_valid, deq;
  logic                          bypass, byp_fire, wr0_lo;
  logic [1:0]                    enq_n;

  assign lo_instr = mem_resp_data[INSTRUCTION_LENGTH-1:0];
  assign hi_instr = mem_resp_data[BUS_WIDTH-1:INSTRUCTION_LENGTH];
  assign hi_pc    = req_addr + HALF_STEP;

  opcode_classifier #(
    .INSTRUCTION_LENGTH(INSTRUCTION_LENGTH),
    .TYPE_WIDTH        (TYPE_WIDTH)
  ) u_classify_lo (
    .instruction     (lo_instr),
    .instruction_type(lo_type)
  );

  opcode_classifier #(
    .INSTRUCTION_LENGTH(INSTRUCTION_LENGTH),
    .TYPE_WIDTH        (TYPE_WIDTH)
  ) u_classify_hi (
    .instruction     (hi_instr),
    .instruction_type(hi_type)
  );

  // A fetch that entered mid-line (pc[2]=1) only keeps the upper half.
  assign upper_only = fetch_pc[2];
  assign resp_take  = (state == FETCH_WAIT) && mem_resp_valid && !redirect_valid;
  assign fifo_valid = (count != '0);
  assign deq        = fifo_valid && out_ready;

`ifdef IFQ_BYPASS_EN
  assign bypass = resp_take && !fifo_valid;
`else
  assign bypass = 1'b0;
`endif
  assign byp_fire = bypass && out_ready;

  // The first instruction of the response is skipped when it leaves through
  // the bypass; wr0_lo says whether slot 0 holds the lower half.
  always_comb begin
    enq_n  = 2'd0;
    wr0_lo = 1'b0;
    if (resp_take) begin
      if (upper_only) begin
        enq_n = byp_fire ? 2'd0 : 2'd1;
      end else begin
        enq_n  = byp_fire ? 2'd1 : 2'd2;
        wr0_lo = !byp_fire;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE: if (!redirect_valid && (count <= ROOM_MAX)) state_next = FETCH_REQ;
      FETCH_REQ:  if (mem_req_ready)
                    state_next = (redirect_valid || drop_pend) ? FETCH_DROP : FETCH_WAIT;
      FETCH_WAIT: if (redirect_valid) state_next = mem_resp_valid ? FETCH_IDLE : FETCH_DROP;
                  else if (mem_resp_valid) state_next = FETCH_IDLE;
      FETCH_DROP: if (mem_resp_valid) state_next = FETCH_IDLE;
      default:    state_next = FETCH_IDLE;
    endcase
  end

  assign mem_req_valid = (state == FETCH_REQ);
  assign mem_req_addr  = req_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH_IDLE;
      fetch_pc  <= RESET_PC;
      req_addr  <= '0;
      drop_pend <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state <= state_next;
      if ((state == FETCH_IDLE) && (state_next == FETCH_REQ))
        req_addr <= {fetch_pc[ADDR_WIDTH-1:3], 3'b000};
      // A redirect seen while the request is still waiting for acceptance
      // must turn its eventual response into a drop.
      drop_pend <= (state == FETCH_REQ) && (drop_pend || redirect_valid) && !mem_req_ready;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        count    <= '0;
        rd_ptr   <= wr_ptr;
      end else begin
        if (resp_take) fetch_pc <= req_addr + LINE_STEP;
        wr_ptr <= wr_ptr + PTR_W'(enq_n);
        rd_ptr <= rd_ptr + PTR_W'(deq);
        count  <= count + CNT_W'(enq_n) - CNT_W'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq_n != 2'd0) begin
      q_instr[wr_ptr] <= wr0_lo ? lo_instr : hi_instr;
      q_type[wr_ptr]  <= wr0_lo ? lo_type  : hi_type;
      q_pc[wr_ptr]    <= wr0_lo ? req_addr : hi_pc;
    end
    if (enq_n == 2'd2) begin
      q_instr[wr_ptr + PTR_ONE] <= hi_instr;
      q_type[wr_ptr + PTR_ONE]  <= hi_type;
      q_pc[wr_ptr + PTR_ONE]    <= hi_pc;
    end
  end

  assign out_valid = fifo_valid || bypass;

  always_comb begin
    instruction      = '0;
    instruction_type = '0;
    out_pc           = '0;
    if (bypass) begin
      instruction      = upper_only ? hi_instr : lo_instr;
      instruction_type = upper_only ? hi_type  : lo_type;
      out_pc           = upper_only ? hi_pc    : req_addr;
    end else if (fifo_valid) begin
      instruction      = q_instr[rd_ptr];
      instruction_type = q_type[rd_ptr];
      out_pc           = q_pc[rd_ptr];
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [2:0]  instruction_type;
  logic [63:0] out_pc;

  int tests = 0;
  int fails = 0;

  instruction_fetch_queue #(
    .ADDR_WIDTH(64), .BUS_WIDTH(64), .INSTRUCTION_LENGTH(32),
    .TYPE_WIDTH(3), .DEPTH(8), .RESET_PC(64'h1000)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .instruction_type(instruction_type),
    .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) for a request, return its address and accept it.
  // A missing request returns all ones.
  task automatic accept(output logic [63:0] a);
    int n = 0;
    while (!mem_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req_valid) a = '1;
    else begin
      a = mem_req_addr;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
    end
  endtask

  task automatic respond(input logic [63:0] d);
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; redirect_valid = 0; redirect_pc = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_data = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid got %b exp 0", mem_req_valid); end
    tests++; if (mem_req_addr !== 64'h0) begin fails++; $display("FAIL rst_req_addr got %h exp 0", mem_req_addr); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL rst_instr got %h exp 0", instruction); end
    tests++; if (instruction_type !== 3'd0) begin fails++; $display("FAIL rst_type got %h exp 0", instruction_type); end
    tests++; if (out_pc !== 64'h0) begin fails++; $display("FAIL rst_pc got %h exp 0", out_pc); end
    reset = 1'b0;
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_first_cycle got %b exp 0", mem_req_valid); end
    @(negedge clk);
    tests++; if (mem_req_valid !== 1'b1) begin fails++; $display("FAIL rst_second_cycle got %b exp 1", mem_req_valid); end
    tests++; if (mem_req_addr !== 64'h1000) begin fails++; $display("FAIL rst_first_addr got %h exp 1000", mem_req_addr); end
  endtask

  task automatic test_basic;
    logic [63:0] a;
    accept(a);
    tests++; if (a !== 64'h1000) begin fails++; $display("FAIL basic_addr got %h exp 1000", a); end
    respond({32'h00000513, 32'h00A00093});
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid0 got %b exp 1", out_valid); end
    tests++; if (instruction !== 32'h00A00093) begin fails++; $display("FAIL basic_instr0 got %h exp 00a00093", instruction); end
    tests++; if (instruction_type !== 3'd1) begin fails++; $display("FAIL basic_type0 got %h exp 1", instruction_type); end
    tests++; if (out_pc !== 64'h1000) begin fails++; $display("FAIL basic_pc0 got %h exp 1000", out_pc); end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (instruction !== 32'h00000513) begin fails++; $display("FAIL basic_instr1 got %h exp 00000513", instruction); end
    tests++; if (instruction_type !== 3'd1) begin fails++; $display("FAIL basic_type1 got %h exp 1", instruction_type); end
    tests++; if (out_pc !== 64'h1004) begin fails++; $display("FAIL basic_pc1 got %h exp 1004", out_pc); end
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1008) begin fails++; $display("FAIL basic_next_req got %b/%h exp 1/1008", mem_req_valid, mem_req_addr); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drained got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_req;
    logic [63:0] a;
    redirect_valid = 1'b1; redirect_pc = 64'h2004;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1008) begin fails++; $display("FAIL redir_req_held got %b/%h exp 1/1008", mem_req_valid, mem_req_addr); end
    accept(a);
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_req_drop got %b exp 0", mem_req_valid); end
    respond(64'hFFFF_FFFF_FFFF_FFFF);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_req_dropped got %b exp 0", out_valid); end
    accept(a);
    tests++; if (a !== 64'h2000) begin fails++; $display("FAIL redir_req_addr got %h exp 2000", a); end
    respond({32'h00000063, 32'hFFFFFFFF});
    tests++; if (out_valid !== 1'b1 || instruction !== 32'h00000063) begin fails++; $display("FAIL redir_upper_instr got %b/%h exp 1/00000063", out_valid, instruction); end
    tests++; if (instruction_type !== 3'd3) begin fails++; $display("FAIL redir_upper_type got %h exp 3", instruction_type); end
    tests++; if (out_pc !== 64'h2004) begin fails++; $display("FAIL redir_upper_pc got %h exp 2004", out_pc); end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_upper_only got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_wait;
    logic [63:0] a;
    accept(a);
    tests++; if (a !== 64'h2008) begin fails++; $display("FAIL wait_addr got %h exp 2008", a); end
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL wait_drop_noreq got %b exp 0", mem_req_valid); end
    respond(64'h0000_0033_0000_0033);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL wait_dropped got %b exp 0", out_valid); end
    accept(a);
    tests++; if (a !== 64'h3000) begin fails++; $display("FAIL wait_target got %h exp 3000", a); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL wait_before_resp got %b exp 0", out_valid); end
    respond({32'h0000006F, 32'h00000063});
    tests++; if (out_valid !== 1'b1 || instruction !== 32'h00000063 || instruction_type !== 3'd3 || out_pc !== 64'h3000) begin fails++; $display("FAIL wait_entry0 got %b/%h/%h/%h exp 1/00000063/3/3000", out_valid, instruction, instruction_type, out_pc); end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (instruction !== 32'h0000006F || instruction_type !== 3'd5 || out_pc !== 64'h3004) begin fails++; $display("FAIL wait_entry1 got %h/%h/%h exp 0000006f/5/3004", instruction, instruction_type, out_pc); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_opcode_sweep;
    logic [63:0] a;
    logic [31:0] ins [6];
    logic [2:0]  typ [6];
    ins = '{32'h00000037, 32'h00000023, 32'h00000033, 32'h0000007F, 32'h00000013, 32'h0000003B};
    typ = '{3'd4, 3'd2, 3'd0, 3'd7, 3'd1, 3'd0};
    for (int k = 0; k < 3; k++) begin
      accept(a);
      tests++; if (a !== 64'h3008 + 64'(8 * k)) begin fails++; $display("FAIL sweep_addr%0d got %h exp %h", k, a, 64'h3008 + 64'(8 * k)); end
      respond({ins[2*k+1], ins[2*k]});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests++; if (out_valid !== 1'b1 || instruction !== ins[i] || instruction_type !== typ[i] || out_pc !== 64'h3008 + 64'(4 * i))
        begin fails++; $display("FAIL sweep_entry%0d got %b/%h/%h/%h exp 1/%h/%h/%h", i, out_valid, instruction, instruction_type, out_pc, ins[i], typ[i], 64'h3008 + 64'(4 * i)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fill;
    logic [63:0] a;
    logic        saw_req;
    logic [31:0] exp_i;
    for (int k = 0; k < 4; k++) begin
      accept(a);
      tests++; if (a !== 64'h3020 + 64'(8 * k)) begin fails++; $display("FAIL fill_addr%0d got %h exp %h", k, a, 64'h3020 + 64'(8 * k)); end
      respond({32'h00000013 | (32'(2 * k + 1) << 20), 32'h00000013 | (32'(2 * k) << 20)});
    end
    saw_req = 1'b0;
    repeat (6) begin
      if (mem_req_valid) saw_req = 1'b1;
      @(negedge clk);
    end
    tests++; if (saw_req !== 1'b0) begin fails++; $display("FAIL fill_no_req_when_full got %b exp 0", saw_req); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_i = 32'h00000013 | (32'(i) << 20);
      tests++; if (out_valid !== 1'b1 || instruction !== exp_i || out_pc !== 64'h3020 + 64'(4 * i))
        begin fails++; $display("FAIL fill_entry%0d got %b/%h/%h exp 1/%h/%h", i, out_valid, instruction, out_pc, exp_i, 64'h3020 + 64'(4 * i)); end
      @(negedge clk);
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fill_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_bypass;
    logic [63:0] a;
    accept(a);
    tests++; if (a !== 64'h3040) begin fails++; $display("FAIL byp_addr got %h exp 3040", a); end
    mem_resp_valid = 1'b1;
    mem_resp_data  = {32'h0000006F, 32'h00000537};
    #1;
`ifdef IFQ_BYPASS_EN
    tests++; if (out_valid !== 1'b1 || instruction !== 32'h00000537 || instruction_type !== 3'd4 || out_pc !== 64'h3040) begin fails++; $display("FAIL byp_same_cycle got %b/%h/%h/%h exp 1/00000537/4/3040", out_valid, instruction, instruction_type, out_pc); end
`else
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL byp_same_cycle got %b exp 0", out_valid); end
`endif
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
`ifdef IFQ_BYPASS_EN
    tests++; if (out_valid !== 1'b1 || instruction !== 32'h0000006F || out_pc !== 64'h3044) begin fails++; $display("FAIL byp_next got %b/%h/%h exp 1/0000006f/3044", out_valid, instruction, out_pc); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL byp_empty got %b exp 0", out_valid); end
`else
    tests++; if (out_valid !== 1'b1 || instruction !== 32'h00000537 || instruction_type !== 3'd4 || out_pc !== 64'h3040) begin fails++; $display("FAIL byp_next got %b/%h/%h/%h exp 1/00000537/4/3040", out_valid, instruction, instruction_type, out_pc); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || instruction !== 32'h0000006F || instruction_type !== 3'd5 || out_pc !== 64'h3044) begin fails++; $display("FAIL byp_second got %b/%h/%h/%h exp 1/0000006f/5/3044", out_valid, instruction, instruction_type, out_pc); end
`endif
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [63:0] a;
    accept(a);
    reset = 1'b1;
    @(negedge clk);
    tests++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0 || mem_req_addr !== 64'h0) begin fails++; $display("FAIL midrst_state got %b/%b/%h exp 0/0/0", mem_req_valid, out_valid, mem_req_addr); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1000) begin fails++; $display("FAIL midrst_restart got %b/%h exp 1/1000", mem_req_valid, mem_req_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_redirect_req();
    test_redirect_wait();
    test_opcode_sweep();
    test_fill();
    test_bypass();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
